// File: rtl/fp_multiplier_pipe_if.sv
// Operand/result handshake bundle for fp_multiplier_pipe.
// master = issue/writeback side, slave = the multiplier.
interface fp_multiplier_pipe_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] Result;

    modport master (
        output in_valid, A, B, out_ready,
        input  in_ready, out_valid, Result
    );

    modport slave (
        input  in_valid, A, B, out_ready,
        output in_ready, out_valid, Result
    );
endinterface

// File: rtl/fp_multiplier_pipe.sv
// 3-stage IEEE-754 multiplier (RNE, flush-to-zero), N = 32 or 64.
// Define FP_MUL_FLAGS_EN to add the {invalid,overflow,underflow,inexact} port.
module fp_multiplier_pipe #(
    parameter int N = 32
) (
    input  logic clk,
    input  logic rst,
    fp_multiplier_pipe_if.slave bus
`ifdef FP_MUL_FLAGS_EN
    ,
    output logic [3:0] flags
`endif
);
    localparam int M = (N == 64) ? 52 : 23;
    localparam int E = (N == 64) ? 11 : 8;
    localparam int P = 2 * M + 2;
    localparam logic [E+1:0] BIAS = (E+2)'((1 << (E - 1)) - 1);
    localparam logic [E+1:0] EMAX = (E+2)'((1 << E) - 1);

    typedef enum logic [1:0] {K_NORM, K_NAN, K_INF, K_ZERO} kind_t;

    typedef struct packed {
        logic         sign;
        kind_t        kind;
`ifdef FP_MUL_FLAGS_EN
        logic         inv;
`endif
        logic [E+1:0] exp;
        logic [M:0]   ma;
        logic [M:0]   mb;
    } s1_t;

    typedef struct packed {
        logic         sign;
        kind_t        kind;
`ifdef FP_MUL_FLAGS_EN
        logic         inv;
`endif
        logic [E+1:0] exp;
        logic [P-1:0] prod;
    } s2_t;

    logic         stall;
    logic         adv;
    logic         v1_q, v2_q, v3_q;
    logic [N-1:0] res_q;
    logic [N-1:0] res_d;
    s1_t          s1_d, s1_q;
    s2_t          s2_q;

    assign stall         = v3_q && !bus.out_ready;
    assign adv           = !stall;
    assign bus.in_ready  = adv;
    assign bus.out_valid = v3_q;
    assign bus.Result    = res_q;

    // S1: unpack, classify, sign and biased exponent sum
    logic         s_a, s_b;
    logic [E-1:0] e_a, e_b;
    logic [M-1:0] f_a, f_b;
    logic         z_a, z_b, i_a, i_b, n_a, n_b;

    assign {s_a, e_a, f_a} = bus.A;
    assign {s_b, e_b, f_b} = bus.B;
    assign z_a = (e_a == '0);
    assign z_b = (e_b == '0);
    assign i_a = (&e_a) && (f_a == '0);
    assign i_b = (&e_b) && (f_b == '0);
    assign n_a = (&e_a) && (f_a != '0);
    assign n_b = (&e_b) && (f_b != '0);

    always_comb begin
        s1_d      = '0;
        s1_d.sign = s_a ^ s_b;
        s1_d.exp  = {2'b00, e_a} + {2'b00, e_b} - BIAS;
        s1_d.ma   = {1'b1, f_a};
        s1_d.mb   = {1'b1, f_b};
        s1_d.kind = K_NORM;
        if (n_a || n_b) begin
            s1_d.kind = K_NAN;
        end else if ((i_a && z_b) || (i_b && z_a)) begin
            s1_d.kind = K_NAN;
`ifdef FP_MUL_FLAGS_EN
            s1_d.inv  = 1'b1;
`endif
        end else if (i_a || i_b) begin
            s1_d.kind = K_INF;
        end else if (z_a || z_b) begin
            s1_d.kind = K_ZERO;
        end
    end

    // S3: normalise, round to nearest even, range check, pack
    logic [M-1:0] mant;
    logic         guard, sticky, inc;
    logic [M:0]   rnd;
    logic [E+1:0] exp_n, exp_f;
    logic         ovf, unf;

    always_comb begin
        if (s2_q.prod[P-1]) begin
            mant   = s2_q.prod[2*M:M+1];
            guard  = s2_q.prod[M];
            sticky = |s2_q.prod[M-1:0];
        end else begin
            mant   = s2_q.prod[2*M-1:M];
            guard  = s2_q.prod[M-1];
            sticky = |s2_q.prod[M-2:0];
        end
        exp_n = s2_q.exp + {{(E+1){1'b0}}, s2_q.prod[P-1]};
        inc   = guard && (sticky || mant[0]);
        rnd   = {1'b0, mant} + {{M{1'b0}}, inc};
        exp_f = exp_n + {{(E+1){1'b0}}, rnd[M]};
        ovf   = !exp_f[E+1] && (exp_f[E:0] >= EMAX[E:0]);
        unf   = exp_f[E+1] || (exp_f == '0);
    end

    always_comb begin
        res_d = '0;
        unique case (s2_q.kind)
            K_NAN:  res_d = '1;
            K_INF:  res_d = {s2_q.sign, {E{1'b1}}, {M{1'b0}}};
            K_ZERO: res_d = {s2_q.sign, {(N-1){1'b0}}};
            default: begin
                if (ovf)
                    res_d = {s2_q.sign, {E{1'b1}}, {M{1'b0}}};
                else if (unf)
                    res_d = {s2_q.sign, {(N-1){1'b0}}};
                else
                    res_d = {s2_q.sign, exp_f[E-1:0], rnd[M-1:0]};
            end
        endcase
    end

`ifdef FP_MUL_FLAGS_EN
    logic [3:0] flags_d;

    always_comb begin
        flags_d = {s2_q.inv, 3'b000};
        if (s2_q.kind == K_NORM)
            flags_d = {1'b0, ovf, unf & ~ovf, guard | sticky | ovf | unf};
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            v3_q  <= 1'b0;
            res_q <= '0;
`ifdef FP_MUL_FLAGS_EN
            flags <= '0;
`endif
        end else if (adv) begin
            v1_q <= bus.in_valid;
            v2_q <= v1_q;
            v3_q <= v2_q;
            if (v2_q) begin
                res_q <= res_d;
`ifdef FP_MUL_FLAGS_EN
                flags <= flags_d;
`endif
            end
        end
    end

    // S2: significand product; datapath needs no reset, valids gate it
    always_ff @(posedge clk) begin
        if (adv) begin
            s1_q      <= s1_d;
            s2_q.sign <= s1_q.sign;
            s2_q.kind <= s1_q.kind;
`ifdef FP_MUL_FLAGS_EN
            s2_q.inv  <= s1_q.inv;
`endif
            s2_q.exp  <= s1_q.exp;
            s2_q.prod <= P'(s1_q.ma) * P'(s1_q.mb);
        end
    end
endmodule

// File: tb/tb_fp_multiplier_pipe.sv
// Directed self-checking bench for fp_multiplier_pipe (N=32 and N=64).
// Flag checks are compiled in only with FP_MUL_FLAGS_EN.
module tb_fp_multiplier_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    fp_multiplier_pipe_if #(.N(32)) b32 ();
    fp_multiplier_pipe_if #(.N(64)) b64 ();

`ifdef FP_MUL_FLAGS_EN
    logic [3:0] flags32;
    logic [3:0] flags64;
`endif

    fp_multiplier_pipe #(.N(32)) dut32 (
        .clk   (clk),
        .rst   (rst),
        .bus   (b32)
`ifdef FP_MUL_FLAGS_EN
        ,
        .flags (flags32)
`endif
    );

    fp_multiplier_pipe #(.N(64)) dut64 (
        .clk   (clk),
        .rst   (rst),
        .bus   (b64)
`ifdef FP_MUL_FLAGS_EN
        ,
        .flags (flags64)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run32(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input logic [3:0] f,
                         input string nm);
        int lat;
        b32.A = a;
        b32.B = b;
        b32.in_valid = 1'b1;
        step();
        b32.in_valid = 1'b0;
        lat = 1;
        while (!b32.out_valid && lat < 8) begin
            step();
            lat++;
        end
        tests++;
        if (lat != 3) begin
            fails++;
            $display("FAIL %s_latency: got %0d cycles expected 3", nm, lat);
        end
        tests++;
        if (b32.Result !== r) begin
            fails++;
            $display("FAIL %s_result: got %h expected %h", nm, b32.Result, r);
        end
`ifdef FP_MUL_FLAGS_EN
        tests++;
        if (flags32 !== f) begin
            fails++;
            $display("FAIL %s_flags: got %b expected %b", nm, flags32, f);
        end
`endif
        step();
    endtask

    task automatic run64(input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] r, input string nm);
        int lat;
        b64.A = a;
        b64.B = b;
        b64.in_valid = 1'b1;
        step();
        b64.in_valid = 1'b0;
        lat = 1;
        while (!b64.out_valid && lat < 8) begin
            step();
            lat++;
        end
        tests++;
        if (lat != 3) begin
            fails++;
            $display("FAIL %s_latency: got %0d cycles expected 3", nm, lat);
        end
        tests++;
        if (b64.Result !== r) begin
            fails++;
            $display("FAIL %s_result: got %h expected %h", nm, b64.Result, r);
        end
        step();
    endtask

    task automatic test_reset();
        b32.in_valid = 1'b0;
        b32.out_ready = 1'b1;
        b32.A = '0;
        b32.B = '0;
        b64.in_valid = 1'b0;
        b64.out_ready = 1'b1;
        b64.A = '0;
        b64.B = '0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        tests++;
        if (b32.out_valid !== 1'b0 || b32.Result !== 32'h0) begin
            fails++;
            $display("FAIL reset32: got valid=%b res=%h expected 0/0",
                     b32.out_valid, b32.Result);
        end
        tests++;
        if (b64.out_valid !== 1'b0 || b64.Result !== 64'h0) begin
            fails++;
            $display("FAIL reset64: got valid=%b res=%h expected 0/0",
                     b64.out_valid, b64.Result);
        end
`ifdef FP_MUL_FLAGS_EN
        tests++;
        if (flags32 !== 4'b0000) begin
            fails++;
            $display("FAIL reset_flags: got %b expected 0000", flags32);
        end
`endif
        step();
        tests++;
        if (b32.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: got %b expected 1", b32.in_ready);
        end
    endtask

    task automatic test_basic();
        run32(32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, "basic");
    endtask

    task automatic test_rounding();
        run32(32'h3F800800, 32'h3F800800, 32'h3F801000, 4'b0001, "tie_even");
        run32(32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001, "sticky");
        run32(32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001, "tie_up");
    endtask

    task automatic test_range();
        run32(32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101, "overflow");
        run32(32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011, "underflow");
    endtask

    task automatic test_specials();
        run32(32'h7F800000, 32'h00000000, 32'hFFFFFFFF, 4'b1000, "inf_x_zero");
        run32(32'h80000000, 32'h3F800000, 32'h80000000, 4'b0000, "neg_zero");
        run32(32'hFF800000, 32'h7F800000, 32'hFF800000, 4'b0000, "neg_inf");
        run32(32'h7FC00000, 32'h00000000, 32'hFFFFFFFF, 4'b0000, "nan_in");
    endtask

    task automatic test_back_to_back();
        logic [31:0] av [8];
        logic [31:0] bv [8];
        logic [31:0] ev [8];
        logic [31:0] held;
        logic        was_stall;
        int          sent;
        int          rcv;
        held = '0;
        was_stall = 1'b0;
        sent = 0;
        rcv = 0;
        for (int i = 0; i < 8; i++) begin
            bv[i] = 32'h40000000 + i * 32'h00012345;
            av[i] = (i % 2 == 1) ? 32'hBF800000 : 32'h3F800000;
            ev[i] = (i % 2 == 1) ? (bv[i] | 32'h80000000) : bv[i];
        end
        for (int c = 0; c < 40; c++) begin
            b32.out_ready = !(c >= 5 && c < 9);
            b32.in_valid = (sent < 8);
            b32.A = av[sent % 8];
            b32.B = bv[sent % 8];
            #1;
            if (b32.out_valid && !b32.out_ready) begin
                tests++;
                if (b32.in_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL stall_in_ready c=%0d: got %b expected 0",
                             c, b32.in_ready);
                end
                if (was_stall) begin
                    tests++;
                    if (b32.Result !== held) begin
                        fails++;
                        $display("FAIL stall_hold c=%0d: got %h expected %h",
                                 c, b32.Result, held);
                    end
                end
                held = b32.Result;
                was_stall = 1'b1;
            end else begin
                was_stall = 1'b0;
            end
            if (b32.out_valid && b32.out_ready) begin
                tests++;
                if (rcv >= 8) begin
                    fails++;
                    $display("FAIL stream_extra: got %h expected none",
                             b32.Result);
                end else if (b32.Result !== ev[rcv]) begin
                    fails++;
                    $display("FAIL stream_%0d: got %h expected %h",
                             rcv, b32.Result, ev[rcv]);
                end
                rcv++;
            end
            if (b32.in_valid && b32.in_ready)
                sent++;
            step();
        end
        b32.in_valid = 1'b0;
        b32.out_ready = 1'b1;
        tests++;
        if (rcv != 8 || sent != 8) begin
            fails++;
            $display("FAIL stream_count: got sent=%0d rcv=%0d expected 8/8",
                     sent, rcv);
        end
    endtask

    task automatic test_double();
        run64(64'h3FF8000000000000, 64'h4000000000000000,
              64'h4008000000000000, "dbl_basic");
    endtask

    task automatic test_reset_in_flight();
        logic seen;
        seen = 1'b0;
        b64.A = 64'h3FF8000000000000;
        b64.B = 64'h4000000000000000;
        b64.in_valid = 1'b1;
        step();
        b64.B = 64'h3FF0000000000000;
        step();
        b64.in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        tests++;
        if (b64.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL flush_valid: got %b expected 0", b64.out_valid);
        end
        for (int i = 0; i < 6; i++) begin
            if (b64.out_valid)
                seen = 1'b1;
            step();
        end
        tests++;
        if (seen !== 1'b0) begin
            fails++;
            $display("FAIL flush_stale: got out_valid=1 expected none");
        end
        run64(64'hC000000000000000, 64'h3FF8000000000000,
              64'hC008000000000000, "dbl_after_rst");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_range();
        test_specials();
        test_back_to_back();
        test_double();
        test_reset_in_flight();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fp_multiplier_pipe.md
Name: fp_multiplier_pipe

Overview:
Pipelined IEEE-754 floating-point multiplier, parametrised for single (N=32) or double (N=64) precision.
- Next generation of the combinational multiplier: adds a 3-stage pipeline, valid/ready handshake, round-to-nearest-even, post-rounding overflow/underflow handling and signed zeros.
- Sits between the operand issue logic and the FPU result writeback.

Parameters:
N, 32, operand/result width; only 32 or 64 legal. Derived: M = 23/52 mantissa bits, E = 8/11 exponent bits, BIAS = 127/1023.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  reset, synchronous, active-high
in_valid  input  1  operands A/B valid this cycle
in_ready  output  1  block can accept operands
A  input  N  operand A
B  input  N  operand B
out_valid  output  1  Result valid
out_ready  input  1  consumer accepts Result
Result  output  N  rounded product
flags  output  4  {invalid, overflow, underflow, inexact}; only present with FP_MUL_FLAGS_EN

Behaviour:
- Reset: out_valid=0, Result=0, flags=0, all stage valid bits=0. in_ready=1 one cycle after reset.
- A reset asserted mid-operation discards all in-flight operations at that edge. No output is produced for them.
- Pipeline stage S1: unpack fields, classify operands (zero, inf, NaN, normal), compute sign = sA^sB, and compute the exponent sum as a signed (E+2)-bit value eA+eB-BIAS.
- Pipeline stage S2: (M+1)x(M+1) significand product, 2M+2 bits wide.
- Pipeline stage S3: normalise, round, check range, pack.
- Latency is exactly 3 cycles from an accepted input (in_valid && in_ready) to out_valid when out_ready is held high. Throughput is 1 per cycle.
- Stall rule: stall = out_valid && !out_ready.
  - While stalled, every stage holds its contents and in_ready=0.
  - in_ready = !stall. Bubbles are not compressed.
  - Result and flags stay stable while out_valid=1 and out_ready=0.
- Normalisation:
  - If product bit 2M+1 is 1: mantissa = bits [2M:M+1], exponent +1, guard = bit M, sticky = OR of bits [M-1:0].
  - Otherwise: mantissa = bits [2M-1:M], guard = bit M-1, sticky = OR of bits [M-2:0].
- Rounding is round-to-nearest, ties-to-even: increment when guard && (sticky || mantissa LSB).
  - A mantissa carry-out sets the mantissa to 0 and adds +1 to the exponent.
  - The range check is done after rounding.
- Range:
  - Final exponent >= 2^E-1 → result is signed infinity; overflow=1, inexact=1.
  - Final exponent <= 0 → result is signed zero (flush to zero); underflow=1, inexact=1.
- Subnormal inputs (exponent field 0, mantissa nonzero) are treated as signed zero.
- Special-case priority, applied in S1 and carried down the pipeline:
  1. Either operand NaN → canonical NaN (all ones), invalid=0.
  2. Inf × zero → canonical NaN, invalid=1.
  3. Either operand inf → infinity with sign = sA^sB.
  4. Either operand zero → zero with sign = sA^sB.
  5. Otherwise the normal path.
- inexact=1 for any normal-path result where guard||sticky is set.

Optional Feature:
FP_MUL_FLAGS_EN:
- Defined: the flags port exists and its 4 bits are registered alongside Result, under the same stall rules.
- Undefined: the port is absent and the flag logic is not synthesised. Result and handshake are identical in both builds.

Test Plan:
1. N=32, 0x3FC00000 × 0x40000000 with out_ready=1 → Result 0x40400000 exactly 3 cycles after acceptance; flags 0000.
2. N=32, 0x3F800800 × 0x3F800800 (exact tie) → 0x3F801000, inexact=1. Then 0x3F800001 × 0x3F800001 → 0x3F800002, inexact=1.
3. N=32, 0x7F000000 × 0x7F000000 → 0x7F800000, overflow=1, inexact=1. Then 0x00800000 × 0x3F000000 → 0x00000000, underflow=1.
4. Specials:
   - 0x7F800000 × 0x00000000 → 0xFFFFFFFF, invalid=1.
   - 0x80000000 × 0x3F800000 → 0x80000000.
   - 0xFF800000 × 0x7F800000 → 0xFF800000.
5. Back-to-back stream of 8 operations, with out_ready low for 4 cycles mid-stream:
   - in_ready drops the same cycle the stall begins.
   - Result is held stable during the stall.
   - All 8 results are delivered in order, with none lost or duplicated.
6. N=64, 0x3FF8000000000000 × 0x4000000000000000 → 0x4008000000000000 after 3 cycles. Assert rst with 2 operations in flight → out_valid=0 next cycle, and no stale result appears afterward.
